// File: rtl/rggen_rtl_pkg.sv
// Shared rggen bus definitions.
// Host-side status encoding matches the AXI resp field bit for bit.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY        = 2'b00,
    RGGEN_EXOKAY      = 2'b01,
    RGGEN_SLAVE_ERROR = 2'b10,
    RGGEN_ERROR       = 2'b11
  } rggen_status;

  function automatic rggen_status rggen_status_from_resp(
    input logic [1:0] resp
  );
    return rggen_status'(resp);
  endfunction

endpackage

// File: rtl/rggen_axi4lite_valid_holder.sv
// AXI valid flop: set on load, cleared once the handshake completes.
// Synchronous active-high reset.
module rggen_axi4lite_valid_holder (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_ready,
  output logic o_valid
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_valid <= 1'b1;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rggen_axi4lite_bridge.sv
// Single-outstanding register-bus host to AXI4-Lite initiator bridge.
// One request in flight; result presented with a one-cycle o_ready pulse.
module rggen_axi4lite_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int                   ADDRESS_WIDTH = 8,
  parameter int                   BUS_WIDTH     = 32,
  parameter logic [2:0]           AXI_PROT      = 3'b000,
  parameter logic [BUS_WIDTH-1:0] ERROR_DATA    = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic                     i_write,
  input  logic [BUS_WIDTH-1:0]     i_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_strobe,
  output logic                     o_ready,
  output logic [1:0]               o_status,
  output logic [BUS_WIDTH-1:0]     o_read_data,
  output logic                     o_awvalid,
  input  logic                     i_awready,
  output logic [ADDRESS_WIDTH-1:0] o_awaddr,
  output logic [2:0]               o_awprot,
  output logic                     o_wvalid,
  input  logic                     i_wready,
  output logic [BUS_WIDTH-1:0]     o_wdata,
  output logic [BUS_WIDTH/8-1:0]   o_wstrb,
  input  logic                     i_bvalid,
  output logic                     o_bready,
  input  logic [1:0]               i_bresp,
  output logic                     o_arvalid,
  input  logic                     i_arready,
  output logic [ADDRESS_WIDTH-1:0] o_araddr,
  output logic [2:0]               o_arprot,
  input  logic                     i_rvalid,
  output logic                     o_rready,
  input  logic [BUS_WIDTH-1:0]     i_rdata,
  input  logic [1:0]               i_rresp
);

  localparam int STROBE_WIDTH = BUS_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    WRITE_REQUEST,
    WRITE_RESPONSE,
    READ_REQUEST,
    READ_RESPONSE,
    HOST_RESPONSE
  } state_e;

  state_e                   state;
  state_e                   state_next;
  logic                     load_write;
  logic                     load_read;
  logic                     aw_done;
  logic                     w_done;
  logic                     capture;
  logic                     b_take;
  logic                     r_take;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [STROBE_WIDTH-1:0]  strobe;
  rggen_status              status;
  logic [BUS_WIDTH-1:0]     read_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A channel counts as done once its valid is low again
  // or its handshake is happening this cycle.
  assign aw_done = !o_awvalid || i_awready;
  assign w_done  = !o_wvalid  || i_wready;

  always_comb begin
    state_next = state;
    load_write = 1'b0;
    load_read  = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_valid && i_write) begin
          load_write = 1'b1;
          state_next = WRITE_REQUEST;
        end else if (i_valid) begin
          load_read  = 1'b1;
          state_next = READ_REQUEST;
        end
      end
      WRITE_REQUEST: begin
        if (aw_done && w_done) begin
          state_next = WRITE_RESPONSE;
        end
      end
      WRITE_RESPONSE: begin
        if (i_bvalid) begin
          state_next = HOST_RESPONSE;
        end
      end
      READ_REQUEST: begin
        if (i_arready) begin
          state_next = READ_RESPONSE;
        end
      end
      READ_RESPONSE: begin
        if (i_rvalid) begin
          state_next = HOST_RESPONSE;
        end
      end
      HOST_RESPONSE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  rggen_axi4lite_valid_holder u_aw_valid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (load_write),
    .i_ready (i_awready),
    .o_valid (o_awvalid)
  );

  rggen_axi4lite_valid_holder u_w_valid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (load_write),
    .i_ready (i_wready),
    .o_valid (o_wvalid)
  );

  rggen_axi4lite_valid_holder u_ar_valid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (load_read),
    .i_ready (i_arready),
    .o_valid (o_arvalid)
  );

  assign capture = (state == IDLE) && i_valid;

  always_ff @(posedge i_clk) begin
    if (capture) begin
      address    <= i_address;
      write_data <= i_write_data;
      strobe     <= i_strobe;
    end
  end

  assign b_take = (state == WRITE_RESPONSE) && i_bvalid;
  assign r_take = (state == READ_RESPONSE) && i_rvalid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      status    <= RGGEN_OKAY;
      read_data <= '0;
    end else if (b_take) begin
      status    <= rggen_status_from_resp(i_bresp);
      read_data <= '0;
    end else if (r_take) begin
      status    <= rggen_status_from_resp(i_rresp);
      read_data <= i_rresp[1] ? ERROR_DATA : i_rdata;
    end
  end

  assign o_awaddr    = address;
  assign o_araddr    = address;
  assign o_awprot    = AXI_PROT;
  assign o_arprot    = AXI_PROT;
  assign o_wdata     = write_data;
  assign o_wstrb     = strobe;
  assign o_bready    = state == WRITE_RESPONSE;
  assign o_rready    = state == READ_RESPONSE;
  assign o_ready     = state == HOST_RESPONSE;
  assign o_status    = status;
  assign o_read_data = read_data;

endmodule

// File: tb/tb_rggen_axi4lite_bridge.sv
// Bench for rggen_axi4lite_bridge: vector table, random traffic
// against a latency/result model, and reset corner sequences.
module tb_rggen_axi4lite_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [7:0]  i_address;
  logic        i_write;
  logic [31:0] i_write_data;
  logic [3:0]  i_strobe;
  logic        o_ready;
  logic [1:0]  o_status;
  logic [31:0] o_read_data;
  logic        o_awvalid, i_awready;
  logic [7:0]  o_awaddr;
  logic [2:0]  o_awprot;
  logic        o_wvalid, i_wready;
  logic [31:0] o_wdata;
  logic [3:0]  o_wstrb;
  logic        i_bvalid, o_bready;
  logic [1:0]  i_bresp;
  logic        o_arvalid, i_arready;
  logic [7:0]  o_araddr;
  logic [2:0]  o_arprot;
  logic        i_rvalid, o_rready;
  logic [31:0] i_rdata;
  logic [1:0]  i_rresp;

  always #5 clk = ~clk;

  rggen_axi4lite_bridge dut (
    .i_clk(clk), .i_rst(rst),
    .i_valid(i_valid), .i_address(i_address), .i_write(i_write),
    .i_write_data(i_write_data), .i_strobe(i_strobe),
    .o_ready(o_ready), .o_status(o_status), .o_read_data(o_read_data),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
    .o_awprot(o_awprot), .o_wvalid(o_wvalid), .i_wready(i_wready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .i_bvalid(i_bvalid),
    .o_bready(o_bready), .i_bresp(i_bresp), .o_arvalid(o_arvalid),
    .i_arready(i_arready), .o_araddr(o_araddr), .o_arprot(o_arprot),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata),
    .i_rresp(i_rresp)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        stray;
    logic [1:0]  exp_st;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  // slave configuration and observations
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  resp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;
  logic        stray_b = 1'b0;
  int          aw_hs = 0, w_hs = 0, ar_hs = 0, ready_cnt = 0;
  logic [7:0]  cap_awaddr, cap_araddr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;

  initial begin
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic pv_aw, pr_aw, pv_w, pr_w, pv_ar, pr_ar, p_rst;
    logic [7:0] p_awaddr, p_araddr;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    pv_aw = 0; pr_aw = 0; pv_w = 0; pr_w = 0;
    pv_ar = 0; pr_ar = 0; p_rst = 1;
    p_awaddr = '0; p_araddr = '0;
    i_awready = 0; i_wready = 0; i_arready = 0;
    i_bvalid = 0; i_rvalid = 0; i_bresp = 2'b11;
    i_rresp = 2'b11; i_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!p_rst) begin
        if (pv_aw && pr_aw) chk("awvalid_clear", o_awvalid, 0);
        if (pv_aw && !pr_aw) begin
          chk("awvalid_hold", o_awvalid, 1);
          chk("awaddr_stable", o_awaddr, p_awaddr);
        end
        if (pv_w && pr_w) chk("wvalid_clear", o_wvalid, 0);
        if (pv_w && !pr_w) chk("wvalid_hold", o_wvalid, 1);
        if (pv_ar && pr_ar) chk("arvalid_clear", o_arvalid, 0);
        if (pv_ar && !pr_ar) begin
          chk("arvalid_hold", o_arvalid, 1);
          chk("araddr_stable", o_araddr, p_araddr);
        end
        if (o_bready) chk("bready_after_hs", aw_hs == 1 && w_hs == 1, 1);
        if (stray_b) chk("bready_stray", o_bready, 0);
      end
      if (o_ready && !rst) ready_cnt++;
      if (o_awvalid) begin
        i_awready = (aw_cnt == aw_dly);
        if (i_awready) begin aw_hs++; cap_awaddr = o_awaddr; end
        aw_cnt++;
      end else begin
        i_awready = 0; aw_cnt = 0;
      end
      if (o_wvalid) begin
        i_wready = (w_cnt == w_dly);
        if (i_wready) begin
          w_hs++; cap_wdata = o_wdata; cap_wstrb = o_wstrb;
        end
        w_cnt++;
      end else begin
        i_wready = 0; w_cnt = 0;
      end
      if (o_arvalid) begin
        i_arready = (ar_cnt == ar_dly);
        if (i_arready) begin ar_hs++; cap_araddr = o_araddr; end
        ar_cnt++;
      end else begin
        i_arready = 0; ar_cnt = 0;
      end
      if (o_bready) begin
        i_bvalid = (b_cnt == b_dly); i_bresp = resp_cfg; b_cnt++;
      end else begin
        i_bvalid = stray_b; i_bresp = 2'b11; b_cnt = 0;
      end
      if (o_rready) begin
        i_rvalid = (r_cnt == r_dly); i_rresp = resp_cfg;
        i_rdata = rdata_cfg; r_cnt++;
      end else begin
        i_rvalid = 0; i_rresp = 2'b11; i_rdata = $urandom; r_cnt = 0;
      end
      pv_aw = o_awvalid; pr_aw = i_awready; p_awaddr = o_awaddr;
      pv_w = o_wvalid; pr_w = i_wready;
      pv_ar = o_arvalid; pr_ar = i_arready; p_araddr = o_araddr;
      p_rst = rst;
    end
  end

  function automatic vec_t mk(input logic wr, input logic [7:0] addr,
      input logic [31:0] data, input logic [3:0] strb,
      input int aw_d, input int w_d, input int b_d, input int ar_d,
      input int r_d, input logic [1:0] resp, input logic [31:0] rdata,
      input logic stray, input logic [1:0] exp_st,
      input logic [31:0] exp_rd, input int exp_lat);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.strb = strb;
    v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d; v.ar_d = ar_d; v.r_d = r_d;
    v.resp = resp; v.rdata = rdata; v.stray = stray;
    v.exp_st = exp_st; v.exp_rd = exp_rd; v.exp_lat = exp_lat;
    return v;
  endfunction

  // Expected result from the protocol rules: the write waits for the
  // slower of AW/W, then B; a read waits for AR, then R.
  function automatic vec_t model(input vec_t v);
    vec_t m;
    int wmax;
    m = v;
    wmax = (v.aw_d > v.w_d) ? v.aw_d : v.w_d;
    m.exp_st = v.resp;
    if (v.wr) m.exp_rd = 32'h0;
    else m.exp_rd = v.resp[1] ? 32'h0 : v.rdata;
    m.exp_lat = 3 + (v.wr ? wmax + v.b_d : v.ar_d + v.r_d);
    return m;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    int lat, rc0;
    logic [1:0] st;
    logic [31:0] rd;
    aw_dly = v.aw_d; w_dly = v.w_d; b_dly = v.b_d;
    ar_dly = v.ar_d; r_dly = v.r_d;
    resp_cfg = v.resp; rdata_cfg = v.rdata; stray_b = v.stray;
    aw_hs = 0; w_hs = 0; ar_hs = 0;
    cap_awaddr = ~v.addr; cap_araddr = ~v.addr;
    cap_wdata = ~v.data; cap_wstrb = ~v.strb;
    rc0 = ready_cnt;
    @(negedge clk);
    i_valid = 1; i_write = v.wr; i_address = v.addr;
    i_write_data = v.data; i_strobe = v.strb;
    lat = 0; st = 'x; rd = 'x;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (o_ready) begin
        st = o_status; rd = o_read_data;
        break;
      end
    end
    i_valid = 0;
    i_write = $urandom; i_address = $urandom;
    i_write_data = $urandom; i_strobe = $urandom;
    chk({tag, "_status"}, st, v.exp_st);
    chk({tag, "_rdata"}, rd, v.exp_rd);
    chk({tag, "_latency"}, lat, v.exp_lat);
    if (v.wr) begin
      chk({tag, "_awaddr"}, cap_awaddr, v.addr);
      chk({tag, "_wdata"}, cap_wdata, v.data);
      chk({tag, "_wstrb"}, cap_wstrb, v.strb);
      chk({tag, "_hs"}, {aw_hs[3:0], w_hs[3:0], ar_hs[3:0]}, 12'h110);
    end else begin
      chk({tag, "_araddr"}, cap_araddr, v.addr);
      chk({tag, "_hs"}, {aw_hs[3:0], w_hs[3:0], ar_hs[3:0]}, 12'h001);
    end
    chk({tag, "_prot"}, {o_awprot, o_arprot}, 6'h0);
    repeat (2) @(negedge clk);
    chk({tag, "_ready_once"}, ready_cnt - rc0, 1);
    chk({tag, "_status_hold"}, o_status, v.exp_st);
    chk({tag, "_rdata_hold"}, o_read_data, v.exp_rd);
    stray_b = 0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valids"}, {o_awvalid, o_wvalid, o_arvalid}, 3'b000);
    chk({tag, "_readies"}, {o_bready, o_rready, o_ready}, 3'b000);
    chk({tag, "_status"}, o_status, 2'b00);
    chk({tag, "_rdata"}, o_read_data, 32'h0);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    int rc0;
    bit seen;
    rst = 1; i_valid = 0; i_write = 0; i_address = '0;
    i_write_data = '0; i_strobe = '0;

    tbl.push_back(mk(1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0,
                     2'b00, 32'h0, 0, 2'b00, 32'h0, 3));
    tbl.push_back(mk(1, 8'h20, 32'h01020304, 4'h5, 0, 3, 0, 0, 0,
                     2'b00, 32'h0, 0, 2'b00, 32'h0, 6));
    tbl.push_back(mk(0, 8'h24, 32'h0, 4'h0, 0, 0, 0, 2, 0,
                     2'b00, 32'h12345678, 0, 2'b00, 32'h12345678, 5));
    tbl.push_back(mk(0, 8'h28, 32'h0, 4'h0, 0, 0, 0, 0, 0,
                     2'b10, 32'hFFFFFFFF, 0, 2'b10, 32'h0, 3));
    tbl.push_back(mk(1, 8'h3C, 32'hA5A5A5A5, 4'h0, 2, 0, 1, 0, 0,
                     2'b01, 32'h0, 0, 2'b01, 32'h0, 6));
    tbl.push_back(mk(1, 8'hFC, 32'h55AA55AA, 4'h8, 2, 2, 0, 0, 0,
                     2'b11, 32'h0, 0, 2'b11, 32'h0, 5));
    tbl.push_back(mk(0, 8'h04, 32'h0, 4'h0, 0, 0, 0, 1, 1,
                     2'b11, 32'h87654321, 0, 2'b11, 32'h0, 5));
    tbl.push_back(mk(0, 8'h40, 32'h0, 4'h0, 0, 0, 0, 0, 2,
                     2'b01, 32'hCAFEF00D, 1, 2'b01, 32'hCAFEF00D, 5));

    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 0;
    @(negedge clk);
    chk_idle_outputs("post_reset");

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    for (int n = 0; n < 40; n++) begin
      v.wr = $urandom_range(0, 1);
      v.addr = $urandom; v.data = $urandom; v.strb = $urandom;
      v.aw_d = $urandom_range(0, 3); v.w_d = $urandom_range(0, 3);
      v.b_d = $urandom_range(0, 3); v.ar_d = $urandom_range(0, 3);
      v.r_d = $urandom_range(0, 3); v.resp = $urandom;
      v.rdata = $urandom;
      v.stray = v.wr ? 1'b0 : 1'($urandom_range(0, 1));
      apply(model(v), $sformatf("rnd%0d", n));
    end

    // reset while waiting on B: abandon without any host response
    b_dly = 1000; aw_dly = 0; w_dly = 0; resp_cfg = 2'b10;
    aw_hs = 0; w_hs = 0;
    rc0 = ready_cnt;
    @(negedge clk);
    i_valid = 1; i_write = 1; i_address = 8'h44;
    i_write_data = 32'h11111111; i_strobe = 4'hF;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_bready) begin seen = 1; break; end
    end
    chk("mid_reset_reach_bready", seen, 1);
    i_valid = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk_idle_outputs("mid_reset");
    rst = 0;
    b_dly = 0;
    repeat (3) @(negedge clk);
    chk("mid_reset_no_ready", ready_cnt - rc0, 0);
    apply(model(mk(0, 8'h48, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00,
                   32'h0BADF00D, 1, 2'b00, 32'h0, 0)), "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
